quad_step_decoder: RTL and testbench

Decodes a 2-bit Gray-coded step sequence (00→01→11→10→00) presented on two asynchronous input pins into direction, single-cycle step pulses, and a signed position count. This is the receive/decode end of the two-wire step-sequence interface produced by the lab1 2-bit state machines. It sits between those pins and the lab display/counter logic. Illegal transitions, where both bits change at once, are flagged rather than counted.

---
 rtl/quad_step_decoder.sv | 155 +++++++++++++++
 tb/tb_quad_step_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: decodes a 2-bit Gray step sequence (00->01->11->10->00 is
// forward) from two asynchronous pins into a signed wrapping position count,
// last-step direction, a one-cycle step pulse and a sticky illegal-jump flag.
// Optional input glitch filter: define QUAD_STEP_FILTER_EN to compile it in.
module quad_step_decoder #(
    parameter int W        = 16,
    parameter int FILT_LEN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a,
    input  logic                b,
    input  logic                clr,
    input  logic                err_clr,
    output logic signed [W-1:0] count,
    output logic                dir,
    output logic                step,
    output logic                err
);

    typedef enum logic {INIT, TRACK} state_t;

    localparam logic signed [W-1:0] ONE = W'(1);

    // Position of a code along the forward sequence, so neighbour tests become
    // a modulo-4 difference.
    function automatic logic [1:0] gray_pos(input logic [1:0] code);
        case (code)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Count update with two's complement wrap; no saturation by design.
    function automatic logic signed [W-1:0] step_count(input logic signed [W-1:0] x,
                                                       input logic up);
        return up ? (x + ONE) : (x - ONE);
    endfunction

    logic [1:0] s1, s2;
    logic       vld_p1, vld_p2;
    logic [1:0] cur;
    logic       cur_vld;
    logic [1:0] prev;
    state_t     state;

    // Two-flop synchronizer; the valid bits mark when s2 holds a real pin sample
    // rather than its reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1     <= 2'b00;
            s2     <= 2'b00;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            s1     <= {a, b};
            s2     <= s1;
            vld_p1 <= 1'b1;
            vld_p2 <= vld_p1;
        end
    end

`ifdef QUAD_STEP_FILTER_EN
    localparam logic [3:0] RUN_MAX = 4'(FILT_LEN - 1);

    logic [1:0] cand;
    logic [3:0] run;
    logic [1:0] acc;
    logic       acc_vld;
    logic       accept;

    // The FILT_LEN-th identical sample is accepted on the same edge it is seen,
    // so the filter adds exactly FILT_LEN-1 edges of latency.
    assign accept  = vld_p2 && (s2 == cand) && (run >= RUN_MAX);
    assign cur     = accept ? s2 : acc;
    assign cur_vld = accept | acc_vld;

    // Run-length filter: a code must repeat FILT_LEN times before it is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand    <= 2'b00;
            run     <= 4'd0;
            acc     <= 2'b00;
            acc_vld <= 1'b0;
        end else if (vld_p2) begin
            if (s2 != cand) begin
                cand <= s2;
                run  <= 4'd1;
            end else if (run < RUN_MAX) begin
                run <= run + 4'd1;
            end
            if (accept) begin
                acc     <= s2;
                acc_vld <= 1'b1;
            end
        end
    end
`else
    logic [3:0] unused_filt_len;
    assign unused_filt_len = 4'(FILT_LEN);
    assign cur             = s2;
    assign cur_vld         = vld_p2;
`endif

    logic [1:0] delta;
    logic       fwd, rev, bad;

    assign delta = gray_pos(cur) - gray_pos(prev);
    assign fwd   = (delta == 2'd1);
    assign rev   = (delta == 2'd3);
    assign bad   = (delta == 2'd2);

    // Tracking FSM with registered outputs; clr overrides the count update and an
    // illegal jump overrides err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            prev  <= 2'b00;
            count <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= 1'b0;
            if (err_clr) err <= 1'b0;
            case (state)
                INIT: begin
                    if (cur_vld) begin
                        prev  <= cur;
                        state <= TRACK;
                    end
                end
                TRACK: begin
                    prev <= cur;
                    if (fwd) begin
                        count <= step_count(count, 1'b1);
                        dir   <= 1'b1;
                        step  <= 1'b1;
                    end else if (rev) begin
                        count <= step_count(count, 1'b0);
                        dir   <= 1'b0;
                        step  <= 1'b1;
                    end else if (bad) begin
                        err <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
            if (clr) count <= '0;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: the stimulus side pushes the expected
// count/dir/err for every legal step; a monitor pops on each step pulse.
module tb_quad_step_decoder;

`ifdef QUAD_STEP_FILTER_EN
    localparam int LAT  = 6;
    localparam int HOLD = 4;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 1;
`endif

    typedef struct packed {
        logic [15:0] cnt;
        logic        dir;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, a, b, clr, err_clr;
    logic [15:0] count;
    logic        dir, step, err;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_steps = 0;

    logic [1:0]  m_code;
    logic [15:0] m_count;
    logic        m_dir, m_err;

    quad_step_decoder #(.W(16), .FILT_LEN(4)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .clr(clr), .err_clr(err_clr),
        .count(count), .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pos(input logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] next_fwd(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] next_rev(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Monitor: every step pulse must match the oldest expected step.
    always @(negedge clk) begin
        if (reset === 1'b1 && step === 1'b1) begin
            n_steps++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step: count=%0h dir=%b, no step expected", count, dir);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("step_count", {16'h0, count}, {16'h0, e.cnt});
                check("step_dir", {31'h0, dir}, {31'h0, e.dir});
                check("step_err", {31'h0, err}, {31'h0, e.err});
            end
        end
    end

    // Drive a new code at a negedge, update the model, optionally line up
    // clr/err_clr with the edge where the decoder reacts, then hold.
    task automatic apply(input logic [1:0] c, input int hold, input bit do_clr, input bit do_eclr);
        int  d;
        bit  stepped;
        d = (pos(c) - pos(m_code) + 4) % 4;
        stepped = 1'b0;
        if (d == 1) begin
            m_count = m_count + 16'd1; m_dir = 1'b1; stepped = 1'b1;
        end else if (d == 3) begin
            m_count = m_count - 16'd1; m_dir = 1'b0; stepped = 1'b1;
        end
        if (do_clr) m_count = 16'h0;
        if (d == 2) m_err = 1'b1;
        else if (do_eclr) m_err = 1'b0;
        if (stepped) sb_q.push_back('{cnt: m_count, dir: m_dir, err: m_err});
        m_code = c;
        {a, b} = c;
        if (do_clr || do_eclr) begin
            repeat (LAT - 1) @(negedge clk);
            clr = do_clr;
            err_clr = do_eclr;
            @(negedge clk);
            clr = 1'b0;
            err_clr = 1'b0;
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic settle();
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        m_count = 16'h0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic measure_latency(input logic [1:0] c);
        int n;
        n = 0;
        apply(c, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) begin
                n = i;
                break;
            end
        end
        check("latency_edges", n, LAT);
        @(negedge clk);
        settle();
    endtask

    initial begin
        logic [15:0] saved;
        int          base_steps;
        logic [1:0]  seq[4];
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;

        reset = 1'b0; a = 1'b1; b = 1'b1; clr = 1'b0; err_clr = 1'b0;
        m_code = 2'b11; m_count = 16'h0; m_dir = 1'b0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", {16'h0, count}, 32'h0);
        check("rst_dir", {31'h0, dir}, 32'h0);
        check("rst_step", {31'h0, step}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);

        // Release reset with 11 held: no step, no error.
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("init_count", {16'h0, count}, 32'h0);
        check("init_err", {31'h0, err}, 32'h0);
        check("init_no_steps", n_steps, 0);

        // 11 -> 01 is one reverse step from 0.
        apply(2'b01, 8, 1'b0, 1'b0);
        check("rev_wrap_count", {16'h0, count}, 32'h0000FFFF);
        check("rev_wrap_dir", {31'h0, dir}, 32'h0);

        // Back to 00, clear, then three forward cycles.
        apply(2'b00, 8, 1'b0, 1'b0);
        settle();
        pulse_clr();
        check("clr_count", {16'h0, count}, 32'h0);
        base_steps = n_steps;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++)
                apply(seq[k], 8, 1'b0, 1'b0);
        settle();
        check("fwd12_count", {16'h0, count}, 32'd12);
        check("fwd12_dir", {31'h0, dir}, 32'h1);
        check("fwd12_err", {31'h0, err}, 32'h0);
        check("fwd12_pulses", n_steps - base_steps, 12);

        // Preload to 0x7FFF with back-to-back steps, then cross the sign boundary.
        pulse_clr();
        for (int i = 0; i < 32767; i++)
            apply(next_fwd(m_code), HOLD, 1'b0, 1'b0);
        settle();
        check("max_pos", {16'h0, count}, 32'h00007FFF);
        apply(next_fwd(m_code), HOLD, 1'b0, 1'b0);
        settle();
        check("pos_wrap", {16'h0, count}, 32'h00008000);
        apply(next_rev(m_code), HOLD, 1'b0, 1'b0);
        settle();
        check("neg_unwrap", {16'h0, count}, 32'h00007FFF);

        // Illegal jumps and err handling, starting from 00.
        while (m_code != 2'b00) apply(next_fwd(m_code), 8, 1'b0, 1'b0);
        settle();
        saved = count;
        apply(2'b11, 8, 1'b0, 1'b0);
        check("illegal_err", {31'h0, err}, 32'h1);
        check("illegal_count", {16'h0, count}, {16'h0, saved});
        apply(2'b01, 8, 1'b0, 1'b0);
        check("resync_count", {16'h0, count}, {16'h0, saved - 16'd1});
        pulse_err_clr();
        check("err_clr", {31'h0, err}, 32'h0);
        apply(2'b10, 8, 1'b0, 1'b1);
        check("err_set_wins", {31'h0, err}, 32'h1);
        pulse_err_clr();
        check("err_clr2", {31'h0, err}, 32'h0);

        // clr on the same edge as a forward step (10 -> 00).
        apply(2'b00, 8, 1'b1, 1'b0);
        check("clr_wins_count", {16'h0, count}, 32'h0);
        check("clr_step_dir", {31'h0, dir}, 32'h1);

        // Five steps, then asynchronous reset mid-sequence.
        for (int k = 0; k < 5; k++) apply(next_fwd(m_code), 8, 1'b0, 1'b0);
        check("count5", {16'h0, count}, 32'd5);
        reset = 1'b0;
        #1;
        check("async_rst_count", {16'h0, count}, 32'h0);
        check("async_rst_dir", {31'h0, dir}, 32'h0);
        check("async_rst_step", {31'h0, step}, 32'h0);
        check("async_rst_err", {31'h0, err}, 32'h0);
        m_count = 16'h0; m_dir = 1'b0; m_err = 1'b0;
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 8) @(negedge clk);
        check("post_rst_count", {16'h0, count}, 32'h0);

`ifdef QUAD_STEP_FILTER_EN
        // Short glitch must be filtered out silently.
        apply(2'b00, 8, 1'b0, 1'b0);
        settle();
        saved = count;
        {a, b} = 2'b01;
        repeat (2) @(negedge clk);
        {a, b} = 2'b00;
        repeat (12) @(negedge clk);
        check("glitch_count", {16'h0, count}, {16'h0, saved});
        check("glitch_err", {31'h0, err}, 32'h0);
`endif

        measure_latency(next_fwd(m_code));

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
